ijtag_multi_reset_tdr: RTL

//  IJTAG test data register that drives NUM_CH independent local resets.

---
 rtl/ijtag_rst_pkg.sv | 19 +
 rtl/ijtag_reset_chan.sv | 78 +++++++
 rtl/ijtag_multi_reset_tdr.sv | 91 +++++++++
 3 files changed

// File: rtl/ijtag_rst_pkg.sv
// ijtag_rst_pkg
//   Shared types for the multi-channel IJTAG reset TDR.
//   - rst_mode_t   : 2-bit per-channel mode field as shifted in through the TDR
//   - chan_state_t : per-channel pulse sequencer state
package ijtag_rst_pkg;

  typedef enum logic [1:0] {
    MODE_FOLLOW  = 2'b00,
    MODE_FORCE   = 2'b01,
    MODE_RELEASE = 2'b10,
    MODE_PULSE   = 2'b11
  } rst_mode_t;

  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_PULSING = 1'b1
  } chan_state_t;

endpackage

// File: rtl/ijtag_reset_chan.sv
// ijtag_reset_chan
//   One local reset channel: holds the mode latch and runs the self-timed
//   pulse down-counter. All state advances on the falling edge of ijtag_tck.
//
//   state      | meaning
//   CH_IDLE    | no pulse in progress; output set by mode latch / ijtag_reset
//   CH_PULSING | pulse in progress; output asserted, counter running
//
// Ports
//   ijtag_tck   in   1        TAP clock (negedge used)
//   ijtag_reset in   1        async active-high reset, also forces to_reset
//   upd         in   1        update strobe (ue & sel)
//   upd_mode    in   2        mode field from the shift register
//   upd_len     in   PULSE_W  pulse length from the shift register
//   to_reset    out  1        local reset, active-high
//   busy        out  1        high while a pulse is in progress
module ijtag_reset_chan
  import ijtag_rst_pkg::*;
#(
  parameter int PULSE_W = 4
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               upd,
  input  rst_mode_t          upd_mode,
  input  logic [PULSE_W-1:0] upd_len,
  output logic               to_reset,
  output logic               busy
);

  localparam logic [PULSE_W-1:0] CNT_ONE = PULSE_W'(1);

  chan_state_t        state_q, state_d;
  rst_mode_t          mode_q, mode_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;

  always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q <= CH_IDLE;
      mode_q  <= MODE_FOLLOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // An update always wins over counting, so a re-update restarts or aborts
  // a pulse on the same edge.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (upd) begin
      mode_d = upd_mode;
      if (upd_mode == MODE_PULSE) begin
        state_d = CH_PULSING;
        cnt_d   = (upd_len == '0) ? CNT_ONE : upd_len;
      end else begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
    end else if (state_q == CH_PULSING) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = CH_IDLE;
        mode_d  = MODE_FOLLOW;
      end
    end
  end

  assign busy = (state_q == CH_PULSING);

  // FOLLOW and RELEASE both pass the external reset through.
  assign to_reset = ijtag_reset | busy | (mode_q == MODE_FORCE);

endmodule

// File: rtl/ijtag_multi_reset_tdr.sv
// ijtag_multi_reset_tdr
//   IJTAG test data register driving NUM_CH independent local resets.
//   Shift layout {pulse_len, mode[NUM_CH-1] .. mode[0]}, bit 0 nearest so.
//   Capture returns {len_latch, stat[NUM_CH-1] .. stat[0]}, stat = {busy, to_reset}.
//
// Ports
//   ijtag_tck       in   1       TAP clock; shift/capture posedge, update negedge
//   ijtag_reset     in   1       async active-high reset
//   ijtag_sel       in   1       instrument select
//   ijtag_ce        in   1       capture enable
//   ijtag_se        in   1       shift enable
//   ijtag_ue        in   1       update enable
//   ijtag_si        in   1       scan in
//   ijtag_so        out  1       scan out, retimed on tck low phase
//   ijtag_to_reset  out  NUM_CH  local resets, active-high
module ijtag_multi_reset_tdr
  import ijtag_rst_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PULSE_W = 4
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  output logic [NUM_CH-1:0] ijtag_to_reset
);

  localparam int SR_LEN = 2 * NUM_CH + PULSE_W;

  logic [SR_LEN-1:0]   sr;
  logic [SR_LEN-1:0]   cap_word;
  logic [2*NUM_CH-1:0] stat;
  logic [NUM_CH-1:0]   busy;
  logic [PULSE_W-1:0]  len_q;
  logic                upd;
  logic                so_q;

  assign upd      = ijtag_ue & ijtag_sel;
  assign cap_word = {len_q, stat};

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      sr <= '0;
    end else if (ijtag_ce && ijtag_sel) begin
      sr <= cap_word;
    end else if (ijtag_se && ijtag_sel) begin
      sr <= {ijtag_si, sr[SR_LEN-1:1]};
    end
  end

  always_ff @(negedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      len_q <= '0;
    end else if (upd) begin
      len_q <= sr[SR_LEN-1 -: PULSE_W];
    end
  end

  // Retiming latch: the next TDR samples so on posedge, so present sr[0]
  // through the low phase and hold it across the high phase.
  always_latch begin
    if (ijtag_reset) begin
      so_q <= 1'b0;
    end else if (!ijtag_tck) begin
      so_q <= sr[0];
    end
  end

  assign ijtag_so = so_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    ijtag_reset_chan #(
      .PULSE_W (PULSE_W)
    ) u_chan (
      .ijtag_tck   (ijtag_tck),
      .ijtag_reset (ijtag_reset),
      .upd         (upd),
      .upd_mode    (rst_mode_t'(sr[2*g +: 2])),
      .upd_len     (sr[SR_LEN-1 -: PULSE_W]),
      .to_reset    (ijtag_to_reset[g]),
      .busy        (busy[g])
    );
    assign stat[2*g +: 2] = {busy[g], ijtag_to_reset[g]};
  end

endmodule
